// File: rtl/wb_slv_pkg.sv
// Shared types and constants for the Wishbone register slave.
// Imported by the interface, counter and top.
package wb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    localparam int CTRL_IDX = 0;
    localparam int EN_BIT   = 7;
    localparam int IE_BIT   = 6;
    localparam int PEND_BIT = 5;

endpackage

// File: rtl/wb_slave_regs_if.sv
// Wishbone classic bus bundle between master BFM and register slave.
// err_o exists only when WB_SLV_ERR_EN is defined.
interface wb_slave_regs_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);

    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_o;
`ifdef WB_SLV_ERR_EN
    logic                  err_o;
`endif

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i,
`ifdef WB_SLV_ERR_EN
        input  err_o,
`endif
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i,
`ifdef WB_SLV_ERR_EN
        output err_o,
`endif
        output dat_o, ack_o
    );

endinterface

// File: rtl/wb_slv_wait_cnt.sv
// Loadable wait-state down-counter; done is high while the count is zero.
module wb_slv_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] val,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= val;
        end else if (dec && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/wb_slave_regs.sv
// Wishbone classic register slave with wait states and gated interrupt.
// Define WB_SLV_ERR_EN to answer out-of-range accesses with err_o.
module wb_slave_regs
    import wb_slv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REGS    = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wb_slave_regs_if.slave bus,
    input  logic           event_i,
    output logic           irq_o
);

    localparam logic [ADDR_WIDTH:0] NREG =
        (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [3:0] WS_LD =
        4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] CTRL_A =
        ADDR_WIDTH'(CTRL_IDX);

    state_t state_q, state_d;

    logic                  req, cnt_load, cnt_dec, cnt_done;
    logic                  go_ack, rd_we, rd_ok, cur_ok;
    logic                  wr_en, wr_ctrl, rd_ctrl;
    logic                  we_q, ack_q, en_q, ie_q, en_d, ie_d;
    logic                  pend_q, irq_q;
    logic [4:0]            low_q;
    logic [ADDR_WIDTH-1:0] adr_q, rd_adr;
    logic [DATA_WIDTH-1:0] wdat_q, rd_val, rdat_q;
    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];

    assign req = bus.cyc_i & bus.stb_i;

    wb_slv_wait_cnt #(.W(4)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .val   (WS_LD),
        .done  (cnt_done)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                adr_q  <= bus.adr_i;
                we_q   <= bus.we_i;
                wdat_q <= bus.dat_i;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        cnt_load = 1'b1;
                        state_d  = WAIT;
                    end else begin
                        state_d  = ACK;
                    end
                end
            end
            WAIT: begin
                if (!req)          state_d = IDLE;
                else if (cnt_done) state_d = ACK;
                else               cnt_dec = 1'b1;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data is captured on entry to ACK, so IDLE uses the live bus.
    always_comb begin
        rd_adr = (state_q == IDLE) ? bus.adr_i : adr_q;
        rd_we  = (state_q == IDLE) ? bus.we_i  : we_q;
        rd_ok  = {1'b0, rd_adr} < NREG;
        rd_val = '0;
        if (rd_adr == CTRL_A) begin
            rd_val[EN_BIT]   = en_q;
            rd_val[IE_BIT]   = ie_q;
            rd_val[PEND_BIT] = pend_q;
            rd_val[4:0]      = low_q;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rd_adr == ADDR_WIDTH'(i)) rd_val = regs_q[i];
        end
    end

    always_comb begin
        go_ack  = (state_d == ACK);
        cur_ok  = {1'b0, adr_q} < NREG;
        wr_en   = (state_q == ACK) && we_q && cur_ok;
        wr_ctrl = wr_en && (adr_q == CTRL_A);
        rd_ctrl = (state_q == ACK) && !we_q && (adr_q == CTRL_A);
        en_d    = wr_ctrl ? wdat_q[EN_BIT] : en_q;
        ie_d    = wr_ctrl ? wdat_q[IE_BIT] : ie_q;
    end

    // Gate with the next IE/EN so irq never outlives a cleared IE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            low_q  <= '0;
            pend_q <= 1'b0;
            irq_q  <= 1'b0;
            for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            en_q   <= en_d;
            ie_q   <= ie_d;
            pend_q <= event_i | (pend_q & ~rd_ctrl);
            irq_q  <= pend_q & ie_d & en_d;
            if (wr_ctrl) low_q <= wdat_q[4:0];
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_en && adr_q == ADDR_WIDTH'(i)) regs_q[i] <= wdat_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_q  <= 1'b0;
            rdat_q <= '0;
        end else begin
`ifdef WB_SLV_ERR_EN
            ack_q  <= go_ack & rd_ok;
`else
            ack_q  <= go_ack;
`endif
            rdat_q <= (go_ack && !rd_we && rd_ok) ? rd_val : '0;
        end
    end

`ifdef WB_SLV_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) err_q <= 1'b0;
        else        err_q <= go_ack & ~rd_ok;
    end

    assign bus.err_o = err_q;
`endif

    assign bus.ack_o = ack_q;
    assign bus.dat_o = rdat_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_slave_regs.sv
// Scoreboard bench for wb_slave_regs: one DUT with 0 and one with 3 wait states.
module tb_wb_slave_regs;
    import wb_slv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ev0 = 1'b0;
    logic ev3 = 1'b0;
    logic irq0, irq3;
    int   total = 0;
    int   bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    wb_slave_regs_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) b0 ();
    wb_slave_regs_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) b3 ();

    wb_slave_regs #(.WAIT_STATES(0)) u0 (
        .clk_i(clk), .rst_i(rst_n), .bus(b0.slave),
        .event_i(ev0), .irq_o(irq0)
    );

    wb_slave_regs #(.WAIT_STATES(3)) u3 (
        .clk_i(clk), .rst_i(rst_n), .bus(b3.slave),
        .event_i(ev3), .irq_o(irq3)
    );

    function automatic logic ack_of(input bit sel);
        return sel ? b3.ack_o : b0.ack_o;
    endfunction

    function automatic logic [7:0] dat_of(input bit sel);
        return sel ? b3.dat_o : b0.dat_o;
    endfunction

`ifdef WB_SLV_ERR_EN
    function automatic logic err_of(input bit sel);
        return sel ? b3.err_o : b0.err_o;
    endfunction
`endif

    task automatic drive(input bit sel, input bit c, input bit w,
                         input logic [2:0] a, input logic [7:0] d);
        if (sel) begin
            b3.cyc_i = c; b3.stb_i = c; b3.we_i = w;
            b3.adr_i = a; b3.dat_i = d;
        end else begin
            b0.cyc_i = c; b0.stb_i = c; b0.we_i = w;
            b0.adr_i = a; b0.dat_i = d;
        end
    endtask

    task automatic xfer(input bit sel, input bit we, input logic [2:0] adr,
                        input logic [7:0] dat, input logic [7:0] exp);
        int n, lat;
        bit fin, oor;
        logic [7:0] e;
        lat = sel ? 4 : 1;
        oor = (adr >= 3'd4);
        n = 0;
        fin = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, we, adr, dat);
        if (!we) exp_q.push_back(oor ? 8'h00 : exp);
        while (!fin && n < 20) begin
            @(negedge clk);
            n++;
`ifdef WB_SLV_ERR_EN
            fin = ack_of(sel) | err_of(sel);
`else
            fin = ack_of(sel);
`endif
        end
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL timeout dut%0d adr=%0d: no ack in %0d cycles",
                     sel ? 3 : 0, adr, n);
            if (!we) e = exp_q.pop_front();
        end else begin
            total++;
            if (n !== lat) begin
                bad++;
                $display("FAIL latency dut%0d adr=%0d: got %0d want %0d",
                         sel ? 3 : 0, adr, n, lat);
            end
`ifdef WB_SLV_ERR_EN
            total++;
            if (ack_of(sel) !== !oor || err_of(sel) !== oor) begin
                bad++;
                $display("FAIL ack_err dut%0d adr=%0d: ack=%b err=%b oor=%b",
                         sel ? 3 : 0, adr, ack_of(sel), err_of(sel), oor);
            end
`endif
            if (!we) begin
                e = exp_q.pop_front();
                total++;
                if (dat_of(sel) !== e) begin
                    bad++;
                    $display("FAIL rdata dut%0d adr=%0d: got %h want %h",
                             sel ? 3 : 0, adr, dat_of(sel), e);
                end
            end
        end
        @(posedge clk);
        #1 drive(sel, 1'b0, 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        total++;
        if (ack_of(sel) !== 1'b0 || dat_of(sel) !== 8'h00) begin
            bad++;
            $display("FAIL ack_one dut%0d: ack=%b dat=%h want 0/00",
                     sel ? 3 : 0, ack_of(sel), dat_of(sel));
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        repeat (2) @(negedge clk);
        total++;
        if ({b0.ack_o, b3.ack_o, irq0, irq3} !== 4'b0 ||
            b0.dat_o !== 8'h00 || b3.dat_o !== 8'h00) begin
            bad++;
            $display("FAIL reset_out: ack=%b%b irq=%b%b want all 0",
                     b0.ack_o, b3.ack_o, irq0, irq3);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int a = 0; a < 4; a++) xfer(1'b0, 1'b0, 3'(a), 8'h00, 8'h00);
    endtask

    task automatic test_rw();
        xfer(1'b0, 1'b1, 3'd1, 8'hA5, 8'h00);
        xfer(1'b0, 1'b0, 3'd1, 8'h00, 8'hA5);
        xfer(1'b0, 1'b1, 3'd3, 8'h5A, 8'h00);
        xfer(1'b0, 1'b0, 3'd3, 8'h00, 8'h5A);
    endtask

    task automatic test_wait();
        int hits;
        xfer(1'b1, 1'b1, 3'd2, 8'h3C, 8'h00);
        xfer(1'b1, 1'b0, 3'd2, 8'h00, 8'h3C);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 3'd2, 8'h77);
        @(posedge clk);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        hits = 0;
        repeat (8) begin
            @(negedge clk);
            if (b3.ack_o !== 1'b0) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL abort_ack: got %0d acks want 0", hits);
        end
        xfer(1'b1, 1'b0, 3'd2, 8'h00, 8'h3C);
    endtask

    task automatic test_irq();
        xfer(1'b0, 1'b1, 3'd0, 8'hFF, 8'h00);
        xfer(1'b0, 1'b0, 3'd0, 8'h00, 8'hDF);
        @(negedge clk) ev0 = 1'b1;
        @(negedge clk) ev0 = 1'b0;
        total++;
        if (irq0 !== 1'b0) begin
            bad++;
            $display("FAIL irq_lag: got %b want 0", irq0);
        end
        @(negedge clk);
        total++;
        if (irq0 !== 1'b1) begin
            bad++;
            $display("FAIL irq_set: got %b want 1", irq0);
        end
        xfer(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF);
        @(negedge clk);
        total++;
        if (irq0 !== 1'b0) begin
            bad++;
            $display("FAIL irq_clr: got %b want 0", irq0);
        end
        xfer(1'b0, 1'b0, 3'd0, 8'h00, 8'hDF);
    endtask

    task automatic test_irq_gate();
        int hits;
        logic [7:0] e;
        xfer(1'b0, 1'b1, 3'd0, 8'h80, 8'h00);
        @(negedge clk) ev0 = 1'b1;
        @(negedge clk) ev0 = 1'b0;
        hits = 0;
        repeat (3) begin
            @(negedge clk);
            if (irq0 !== 1'b0) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL irq_gated: irq high %0d cycles want 0", hits);
        end
        xfer(1'b0, 1'b1, 3'd0, 8'hC0, 8'h00);
        @(negedge clk);
        total++;
        if (irq0 !== 1'b1) begin
            bad++;
            $display("FAIL irq_ie: got %b want 1", irq0);
        end
        xfer(1'b0, 1'b0, 3'd0, 8'h00, 8'hE0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
        exp_q.push_back(8'hC0);
        @(posedge clk);
        #1 ev0 = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (b0.ack_o !== 1'b1 || b0.dat_o !== e) begin
            bad++;
            $display("FAIL coin_rd: ack=%b dat=%h want 1/%h",
                     b0.ack_o, b0.dat_o, e);
        end
        @(posedge clk);
        #1 ev0 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        xfer(1'b0, 1'b0, 3'd0, 8'h00, 8'hE0);
        xfer(1'b0, 1'b0, 3'd0, 8'h00, 8'hC0);
    endtask

    task automatic test_oor();
        xfer(1'b0, 1'b1, 3'd2, 8'h12, 8'h00);
        xfer(1'b0, 1'b1, 3'd6, 8'h55, 8'h00);
        xfer(1'b0, 1'b0, 3'd6, 8'h00, 8'h00);
        xfer(1'b0, 1'b0, 3'd4, 8'h00, 8'h00);
        xfer(1'b0, 1'b0, 3'd2, 8'h00, 8'h12);
    endtask

    task automatic test_back_to_back();
        logic [5:0] seen;
        logic [7:0] e;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'd1, 8'h00);
        repeat (3) exp_q.push_back(8'hA5);
        seen = '0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            seen[n] = b0.ack_o;
            if (b0.ack_o === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (b0.dat_o !== e) begin
                    bad++;
                    $display("FAIL b2b_data: got %h want %h", b0.dat_o, e);
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        total++;
        if (seen !== 6'b010101) begin
            bad++;
            $display("FAIL b2b_ack: pattern %b want 010101", seen);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int hits;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 3'd3, 8'h99);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (b3.ack_o !== 1'b0 || u3.state_q !== IDLE) begin
            bad++;
            $display("FAIL rst_mid: ack=%b state=%0d want 0/IDLE",
                     b3.ack_o, u3.state_q);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (b3.ack_o !== 1'b0) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL rst_noack: got %0d acks want 0", hits);
        end
        xfer(1'b1, 1'b0, 3'd2, 8'h00, 8'h00);
        xfer(1'b1, 1'b0, 3'd3, 8'h00, 8'h00);
        xfer(1'b0, 1'b0, 3'd1, 8'h00, 8'h00);
        xfer(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        xfer(1'b1, 1'b1, 3'd3, 8'h5A, 8'h00);
        xfer(1'b1, 1'b0, 3'd3, 8'h00, 8'h5A);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rw();
        test_wait();
        test_irq();
        test_irq_gate();
        test_oor();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_slave_regs.md
Name: wb_slave_regs

Overview:
- Synthesizable Wishbone classic-cycle slave (responder) for the DUT-side end of the bus our master BFM drives.
- Provides a small register file with programmable wait states, and an interrupt gated by an IE bit in register 0.
- Serves as a standalone bus target for BFM self-checks and as the register front end for future controller models.

Parameters:
- ADDR_WIDTH, 3, Wishbone address width; addresses at or above NUM_REGS are out of range.
- DATA_WIDTH, 8, Wishbone data width; must be at least 8.
- NUM_REGS, 4, number of implemented registers, 2 to 2**ADDR_WIDTH.
- WAIT_STATES, 0, extra cycles inserted before ack_o; range 0 to 15.

Ports:
- clk_i  input  1  system clock; all logic is on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- cyc_i  input  1  bus cycle valid.
- stb_i  input  1  strobe.
- we_i  input  1  1 = write, 0 = read.
- adr_i  input  ADDR_WIDTH  register address.
- dat_i  input  DATA_WIDTH  write data.
- dat_o  output  DATA_WIDTH  read data; valid only while ack_o = 1.
- ack_o  output  1  transfer acknowledge, one cycle per transfer.
- event_i  input  1  interrupt-source pulse, synchronous to clk_i.
- irq_o  output  1  interrupt request, level.
- err_o  output  1  error acknowledge; exists only when WB_SLV_ERR_EN is defined.

Behaviour:
- Reset (rst_i = 0, asynchronous): ack_o = 0, err_o = 0, dat_o = 0, irq_o = 0, all registers = 0, FSM = IDLE.
- Reg0 (CTRL) layout:
  - bit7 EN, R/W.
  - bit6 IE, R/W.
  - bit5 PEND, read-only; writes to it are ignored.
  - bits4:0 R/W.
  - Upper bits beyond 7 read 0.
- Regs 1..NUM_REGS-1: plain R/W storage, full DATA_WIDTH.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on cyc_i & stb_i, latch adr_i, we_i and dat_i. Go to WAIT if WAIT_STATES > 0 (counter loaded with WAIT_STATES-1); otherwise go to ACK.
  - WAIT: counter decrements each cycle; at 0, go to ACK. If cyc_i or stb_i drops, abort to IDLE with no write and no ack.
  - ACK: ack_o = 1 for exactly this cycle; go to IDLE.
- Latency: ack_o rises 1 + WAIT_STATES cycles after the edge on which the request is sampled.
- Back-to-back: a master that keeps stb_i high after ack starts a new transfer from IDLE. Minimum transfer period is 2 + WAIT_STATES cycles; no double ack is possible.
- Writes: commit to the register on the ACK-state edge, using the latched address and data.
- Reads: dat_o is registered and driven with ack_o; dat_o returns to 0 when ack_o = 0.
- Out-of-range address, without the macro: ack_o as normal, read returns 0, write ignored.
- PEND:
  - Set on any cycle with event_i = 1.
  - Cleared when a read of reg0 is acked.
  - Set and clear in the same cycle: set wins.
  - A write to reg0 never changes PEND.
- irq_o = registered (PEND & IE & EN); it follows PEND by one cycle. irq_o must never be 1 while IE = 0.
- Reset asserted mid-transfer: the transfer is dropped and no ack is issued after reset deasserts.

Optional Feature:
- Macro: WB_SLV_ERR_EN.
- Defined:
  - err_o port exists.
  - An out-of-range access ends with err_o = 1 for one cycle in place of ack_o, at the same latency; no write, dat_o = 0.
  - err_o and ack_o are never both 1.
- Undefined: err_o is absent, and out-of-range accesses behave as described in Behaviour.

Decomposition:
- Shared package wb_slv_pkg holds:
  - FSM state enum.
  - Register index constants (CTRL_IDX = 0).
  - Bit positions EN_BIT = 7, IE_BIT = 6, PEND_BIT = 5.
- Sub-module wb_slv_wait_cnt: loadable down-counter with a done flag, used by the FSM.

Test Plan:
- Write 0xA5 to adr 1, then read adr 1 (WAIT_STATES = 0) -> read returns 0xA5; ack_o high exactly 1 cycle, 1 cycle after strobe sampled.
- WAIT_STATES = 3: write 0x3C to adr 2, then read -> ack at cycle 4 after strobe; data 0x3C; cyc_i dropped at cycle 2 of a second write -> no ack, reg unchanged.
- Write 0xFF to reg0 -> read returns 0xDF (PEND = 0, not writable); pulse event_i -> irq_o = 1 one cycle after PEND sets; read reg0 returns 0xFF and clears PEND -> irq_o falls.
- Reg0 = 0x80 (IE = 0), pulse event_i -> PEND = 1, irq_o stays 0; then write 0xC0 -> irq_o = 1. Event coincident with reg0 read-ack -> PEND stays 1.
- Access adr 6 (NUM_REGS = 4) -> without macro, ack with data 0x00; with WB_SLV_ERR_EN, err_o = 1, ack_o = 0, and regs unchanged.
- Assert rst_i low mid-WAIT -> ack_o = 0, all regs 0x00, FSM = IDLE; the next transfer completes normally.
